// File: rtl/robot_pkg.sv
// Shared encodings for the motion sequencer: FSM states, command codes and drive-bit layout.
package robot_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FWD      = 3'd1,
        S_TURN     = 3'd2,
        S_ARM_EXT  = 3'd3,
        S_ARM_HOLD = 3'd4,
        S_ARM_RET  = 3'd5,
        S_GAP      = 3'd6
    } state_t;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_FWD  = 2'b01;
    localparam logic [1:0] CMD_TURN = 2'b10;
    localparam logic [1:0] CMD_REM  = 2'b11;

    localparam int DRV_ML  = 0;
    localparam int DRV_MR  = 1;
    localparam int DRV_DIR = 2;
    localparam int DRV_EXT = 3;
    localparam int DRV_RET = 4;
    localparam int NDRV    = 5;

    function automatic logic [NDRV-1:0] drive_of(state_t s);
        logic [NDRV-1:0] d;
        d = '0;
        case (s)
            S_FWD: begin
                d[DRV_ML] = 1'b1;
                d[DRV_MR] = 1'b1;
            end
            S_TURN: begin
                d[DRV_ML]  = 1'b1;
                d[DRV_MR]  = 1'b1;
                d[DRV_DIR] = 1'b1;
            end
            S_ARM_EXT: d[DRV_EXT] = 1'b1;
            S_ARM_RET: d[DRV_RET] = 1'b1;
            default:   d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/robot_motion_sequencer_phase_timer.sv
// Loadable down-counter that times each sequencer phase; zero_o marks the last cycle of a phase.
module phase_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] value_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= value_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - CW'(1);
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/robot_motion_sequencer.sv
// Turns level commands from the wall-following FSM into timed wheel/arm sequences,
// one command at a time, with abort handling and a 90-degree heading count.
module robot_motion_sequencer
    import robot_pkg::*;
#(
    parameter int FWD_CYCLES  = 8,
    parameter int TURN_CYCLES = 12,
    parameter int ARM_CYCLES  = 6,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int CW          = 8
) (
    input  logic       clockc2,
    input  logic       reset,
    input  logic       avancar,
    input  logic       girar,
    input  logic       remover,
    input  logic       abort,
    output logic       motor_l,
    output logic       motor_r,
    output logic       dir_r,
    output logic       arm_ext,
    output logic       arm_ret,
    output logic       busy,
    output logic [1:0] cmd_code,
    output logic       cmd_done,
    output logic       aborted,
    output logic [1:0] heading
);

    state_t            state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic              arm_abrt_q, arm_abrt_d;
    logic [1:0]        heading_q, heading_d;
    logic              done_q, done_d;
    logic              abp_q, abp_d;
    logic [NDRV-1:0]   drv_q;
    logic [1:0]        code_q;
    logic              busy_q;
    logic              ld;
    logic [CW-1:0]     ld_val;
    logic              zero;

    function automatic logic [CW-1:0] phase_len(state_t s);
        case (s)
            S_FWD:      return CW'(FWD_CYCLES - 1);
            S_TURN:     return CW'(TURN_CYCLES - 1);
            S_ARM_EXT:  return CW'(ARM_CYCLES - 1);
            S_ARM_HOLD: return CW'(HOLD_CYCLES - 1);
            S_ARM_RET:  return CW'(ARM_CYCLES - 1);
            S_GAP:      return CW'(GAP_CYCLES - 1);
            default:    return '0;
        endcase
    endfunction

    phase_timer #(.CW(CW)) u_timer (
        .clk    (clockc2),
        .rst    (reset),
        .load_i (ld),
        .value_i(ld_val),
        .zero_o (zero)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        arm_abrt_d = arm_abrt_q;
        heading_d  = heading_q;
        done_d     = 1'b0;
        abp_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                arm_abrt_d = 1'b0;
                if (!abort) begin
                    if (remover) begin
                        state_d = S_ARM_EXT;
                        cmd_d   = CMD_REM;
                    end else if (girar) begin
                        state_d = S_TURN;
                        cmd_d   = CMD_TURN;
                    end else if (avancar) begin
                        state_d = S_FWD;
                        cmd_d   = CMD_FWD;
                    end
                end
            end
            S_FWD, S_TURN: begin
                // abort wins over a same-edge completion
                if (abort) begin
                    state_d = S_GAP;
                    abp_d   = 1'b1;
                end else if (zero) begin
                    state_d = S_GAP;
                    done_d  = 1'b1;
                    if (state_q == S_TURN)
                        heading_d = heading_q + 2'd1;
                end
            end
            S_ARM_EXT, S_ARM_HOLD: begin
                if (abort) begin
                    state_d    = S_ARM_RET;
                    abp_d      = 1'b1;
                    arm_abrt_d = 1'b1;
                end else if (zero) begin
                    state_d = (state_q == S_ARM_EXT) ? S_ARM_HOLD : S_ARM_RET;
                end
            end
            S_ARM_RET: begin
                if (zero) begin
                    state_d = S_GAP;
                    done_d  = !arm_abrt_q;
                end
            end
            S_GAP: begin
                if (zero)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ld     = (state_d != state_q);
        ld_val = phase_len(state_d);
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_ff @(posedge clockc2) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cmd_q      <= CMD_NONE;
            arm_abrt_q <= 1'b0;
            heading_q  <= 2'd0;
            done_q     <= 1'b0;
            abp_q      <= 1'b0;
            drv_q      <= '0;
            code_q     <= CMD_NONE;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            arm_abrt_q <= arm_abrt_d;
            heading_q  <= heading_d;
            done_q     <= done_d;
            abp_q      <= abp_d;
            drv_q      <= drive_of(state_d);
            code_q     <= (state_d == S_IDLE) ? CMD_NONE : cmd_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign motor_l  = drv_q[DRV_ML];
    assign motor_r  = drv_q[DRV_MR];
    assign dir_r    = drv_q[DRV_DIR];
    assign arm_ext  = drv_q[DRV_EXT];
    assign arm_ret  = drv_q[DRV_RET];
    assign busy     = busy_q;
    assign cmd_code = code_q;
    assign cmd_done = done_q;
    assign aborted  = abp_q;
    assign heading  = heading_q;

endmodule
